dcache_direct_mapped: RTL and testbench
=======================================

Name: dcache_direct_mapped

Overview:
Direct-mapped, write-back, write-allocate data cache that is the responder on the processor data-cache interface. It accepts word-addressed read and write requests from the pipeline and returns hit data in the same cycle. On a miss it holds the processor stall and runs block transfers on a 128-bit memory-side interface. It sits between the pipeline core and main memory; an identical instance with writes tied off serves as the instruction cache.

Parameters:
INDEX_BITS, 3, number of line-index bits; the cache has 2^INDEX_BITS lines of 4 words each.
TAG_BITS, 25, tag width; must equal 28 - INDEX_BITS.

Ports:
clk  input  1  clock, all state updates on the rising edge
rst_n  input  1  synchronous active-low reset
proc_read  input  1  processor read request
proc_write  input  1  processor write request
proc_addr  input  30  word address: [1:0] word offset, [INDEX_BITS+1:2] index, [29:INDEX_BITS+2] tag
proc_wdata  input  32  write word, stored unmodified (no byte reordering)
proc_stall  output  1  high while the current request is not yet complete
proc_rdata  output  32  read word, valid when proc_read=1 and proc_stall=0
mem_read  output  1  block read request to memory
mem_write  output  1  block write request to memory
mem_addr  output  28  block address, equal to word address [29:2]
mem_wdata  output  128  victim block, word 0 in [31:0]
mem_ready  input  1  memory completion pulse; one cycle per transaction
mem_rdata  input  128  fill block, valid when mem_ready=1; word 0 in [31:0]

Behaviour:
- Reset (rst_n=0 at a rising edge): clear all valid and dirty bits, state to IDLE, mem_read=0, mem_write=0. Data and tag arrays are not reset. Reset overrides an in-flight transfer; a mem_ready arriving later is ignored in IDLE.
- Request: req = proc_read | proc_write. If both are high, the request is a write.
- Hit: line[index].valid and its tag equal to the address tag. Hit detection is combinational.
- proc_stall = req & (state != IDLE | !hit). With no request, stall is 0.
- proc_rdata = line[index].word[offset] combinationally. It is don't-care on a miss.
- The processor holds its request stable while proc_stall=1.
- State IDLE:
  - Read hit: zero-latency, stall=0.
  - Write hit: at the edge, write the word and set dirty.
  - Miss on a clean or invalid line: go to ALLOCATE.
  - Miss on a valid dirty line: go to WRITEBACK.
- State WRITEBACK:
  - mem_write=1; mem_addr = {victim tag, index}; mem_wdata = victim line.
  - Hold all three until mem_ready=1, then go to ALLOCATE.
- State ALLOCATE:
  - mem_read=1; mem_addr = proc_addr[29:2].
  - On mem_ready=1: write mem_rdata into the line, update the tag, set valid=1 and dirty=0, then return to IDLE.
- The request resolves as a hit in the first IDLE cycle after the fill. Miss latency = fill wait + 1 cycle, plus writeback wait if the victim is dirty.
- mem_read and mem_write are registered, never both high, and drop the cycle after mem_ready.
- mem_ready is ignored in IDLE.
- The fill never merges write data directly; the pending write completes as a write hit after the fill.
- mem_addr holds its last value when idle.

Test Plan:
- Read miss, cold cache: reset, proc_read addr 0x0000_0010.
  - Expect stall=1; mem_read=1 with mem_addr=0x0000004.
  - mem_ready after 3 cycles with rdata {0xD,0xC,0xB,0xA} → next cycle stall=0, proc_rdata=0xA.
- Read hit: reread addr 0x11 → stall=0 same cycle, proc_rdata=0xB, no memory request.
- Write hit: write 0x12345678 to 0x12, then read 0x12 → stall=0 on both, rdata=0x12345678.
- Dirty eviction: read 0x0000_0030 (same index 4, different tag).
  - Expect mem_write=1, mem_addr=0x0000004, mem_wdata[95:64]=0x12345678.
  - After mem_ready: mem_read=1, mem_addr=0x000000C.
  - After fill, stall=0.
- Write miss, clean line: write 0x55 to 0x100.
  - Expect ALLOCATE only, no mem_write.
  - After fill, the word is updated and dirty is set; a later conflicting miss writes it back.
- Reset mid-miss: assert rst_n=0 during ALLOCATE.
  - Expect mem_read=0, stall=0 with no request.
  - A subsequent read of 0x10 misses again (valid cleared).

Source files
------------

// File: rtl/dcache_direct_mapped.sv
// Direct-mapped, write-back, write-allocate data cache with 4-word lines.
// Hits resolve combinationally; misses stall the pipeline during 128-bit block transfers.
module dcache_direct_mapped #(
  parameter int INDEX_BITS = 3,
  parameter int TAG_BITS   = 25
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         proc_read,
  input  logic         proc_write,
  input  logic [29:0]  proc_addr,
  input  logic [31:0]  proc_wdata,
  output logic         proc_stall,
  output logic [31:0]  proc_rdata,
  output logic         mem_read,
  output logic         mem_write,
  output logic [27:0]  mem_addr,
  output logic [127:0] mem_wdata,
  input  logic         mem_ready,
  input  logic [127:0] mem_rdata
);

  localparam int LINES = 1 << INDEX_BITS;

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] WRITEBACK = 2'd1;
  localparam logic [1:0] ALLOCATE  = 2'd2;

  logic [1:0]          state;
  logic [LINES-1:0]    valid_q;
  logic [LINES-1:0]    dirty_q;
  logic [127:0]        data_q [LINES];
  logic [TAG_BITS-1:0] tag_q  [LINES];

  logic [INDEX_BITS-1:0] idx;
  logic [TAG_BITS-1:0]   tag;
  logic [1:0]            off;
  logic [6:0]            woff;
  logic                  req;
  logic                  hit;
  logic                  victim_dirty;
  logic                  idle_miss;
  logic                  wr_hit;
  logic                  fill;
  logic                  wb_done;

  assign off  = proc_addr[1:0];
  assign idx  = proc_addr[INDEX_BITS+1:2];
  assign tag  = proc_addr[29:INDEX_BITS+2];
  assign woff = {off, 5'b0};

  assign req          = proc_read | proc_write;
  assign hit          = valid_q[idx] && (tag_q[idx] == tag);
  assign victim_dirty = valid_q[idx] & dirty_q[idx];

  assign proc_stall = req & ((state != IDLE) | ~hit);
  assign proc_rdata = data_q[idx][woff +: 32];

  // A simultaneous read and write is treated as a write.
  assign idle_miss = rst_n & (state == IDLE) & req & ~hit;
  assign wr_hit    = rst_n & (state == IDLE) & proc_write & hit;
  assign fill      = rst_n & (state == ALLOCATE) & mem_ready;
  assign wb_done   = rst_n & (state == WRITEBACK) & mem_ready;

  // Control: state, line status bits and memory request strobes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      valid_q   <= '0;
      dirty_q   <= '0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (wr_hit) begin
            dirty_q[idx] <= 1'b1;
          end else if (idle_miss) begin
            if (victim_dirty) begin
              state     <= WRITEBACK;
              mem_write <= 1'b1;
            end else begin
              state    <= ALLOCATE;
              mem_read <= 1'b1;
            end
          end
        end
        WRITEBACK: begin
          if (mem_ready) begin
            state     <= ALLOCATE;
            mem_write <= 1'b0;
            mem_read  <= 1'b1;
          end
        end
        ALLOCATE: begin
          if (mem_ready) begin
            state        <= IDLE;
            mem_read     <= 1'b0;
            valid_q[idx] <= 1'b1;
            dirty_q[idx] <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          mem_read  <= 1'b0;
          mem_write <= 1'b0;
        end
      endcase
    end
  end

  // Data path: line storage and memory-side address/victim registers, no reset.
  always_ff @(posedge clk) begin
    if (fill) begin
      data_q[idx] <= mem_rdata;
      tag_q[idx]  <= tag;
    end else if (wr_hit) begin
      data_q[idx][woff +: 32] <= proc_wdata;
    end

    if (idle_miss) begin
      if (victim_dirty) begin
        mem_addr  <= {tag_q[idx], idx};
        mem_wdata <= data_q[idx];
      end else begin
        mem_addr <= proc_addr[29:2];
      end
    end else if (wb_done) begin
      mem_addr <= proc_addr[29:2];
    end
  end

endmodule

// File: tb/tb_dcache_direct_mapped.sv
// Directed self-checking bench for dcache_direct_mapped: misses, hits, write-back
// eviction, write-allocate and reset during a block fill.
module tb_dcache_direct_mapped;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         proc_read;
  logic         proc_write;
  logic [29:0]  proc_addr;
  logic [31:0]  proc_wdata;
  logic         proc_stall;
  logic [31:0]  proc_rdata;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic         mem_ready;
  logic [127:0] mem_rdata;

  int pass_cnt = 0;
  int total_cnt = 0;

  dcache_direct_mapped #(.INDEX_BITS(3), .TAG_BITS(25)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .proc_read  (proc_read),
    .proc_write (proc_write),
    .proc_addr  (proc_addr),
    .proc_wdata (proc_wdata),
    .proc_stall (proc_stall),
    .proc_rdata (proc_rdata),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ready  (mem_ready),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running required finished");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle mem_ready pulse carrying a fill block.
  task automatic mem_pulse(input logic [127:0] blk);
    mem_ready = 1'b1;
    mem_rdata = blk;
    tick();
    mem_ready = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; proc_read = 1'b0; proc_write = 1'b0; proc_addr = '0;
    proc_wdata = '0; mem_ready = 1'b0; mem_rdata = '0;
    tick(); tick();
    rst_n = 1'b1;
    #1;
    total_cnt++; if (mem_read !== 1'b0) $display("FAIL reset_mem_read: got %b required 0", mem_read); else pass_cnt++;
    total_cnt++; if (mem_write !== 1'b0) $display("FAIL reset_mem_write: got %b required 0", mem_write); else pass_cnt++;
    total_cnt++; if (proc_stall !== 1'b0) $display("FAIL reset_stall: got %b required 0", proc_stall); else pass_cnt++;
  endtask

  task automatic test_read_miss();
    proc_read = 1'b1; proc_addr = 30'h10;
    #1;
    total_cnt++; if (proc_stall !== 1'b1) $display("FAIL miss_stall: got %b required 1", proc_stall); else pass_cnt++;
    tick();
    total_cnt++; if (mem_read !== 1'b1) $display("FAIL miss_mem_read: got %b required 1", mem_read); else pass_cnt++;
    total_cnt++; if (mem_write !== 1'b0) $display("FAIL miss_mem_write: got %b required 0", mem_write); else pass_cnt++;
    total_cnt++; if (mem_addr !== 28'h4) $display("FAIL miss_mem_addr: got %h required 0000004", mem_addr); else pass_cnt++;
    tick(); tick();
    total_cnt++; if (proc_stall !== 1'b1) $display("FAIL miss_wait_stall: got %b required 1", proc_stall); else pass_cnt++;
    mem_pulse({32'hD, 32'hC, 32'hB, 32'hA});
    total_cnt++; if (proc_stall !== 1'b0) $display("FAIL fill_stall: got %b required 0", proc_stall); else pass_cnt++;
    total_cnt++; if (proc_rdata !== 32'hA) $display("FAIL fill_rdata: got %h required 0000000a", proc_rdata); else pass_cnt++;
    total_cnt++; if (mem_read !== 1'b0) $display("FAIL fill_mem_read_drop: got %b required 0", mem_read); else pass_cnt++;
  endtask

  task automatic test_read_hit();
    proc_addr = 30'h11;
    #1;
    total_cnt++; if (proc_stall !== 1'b0) $display("FAIL hit_stall: got %b required 0", proc_stall); else pass_cnt++;
    total_cnt++; if (proc_rdata !== 32'hB) $display("FAIL hit_rdata: got %h required 0000000b", proc_rdata); else pass_cnt++;
    tick();
    total_cnt++; if (mem_read !== 1'b0) $display("FAIL hit_no_mem_read: got %b required 0", mem_read); else pass_cnt++;
  endtask

  task automatic test_write_hit();
    proc_read = 1'b0; proc_write = 1'b1; proc_addr = 30'h12; proc_wdata = 32'h12345678;
    #1;
    total_cnt++; if (proc_stall !== 1'b0) $display("FAIL wr_hit_stall: got %b required 0", proc_stall); else pass_cnt++;
    tick();
    proc_write = 1'b0; proc_read = 1'b1;
    #1;
    total_cnt++; if (proc_stall !== 1'b0) $display("FAIL wr_hit_read_stall: got %b required 0", proc_stall); else pass_cnt++;
    total_cnt++; if (proc_rdata !== 32'h12345678) $display("FAIL wr_hit_rdata: got %h required 12345678", proc_rdata); else pass_cnt++;
    total_cnt++; if (mem_write !== 1'b0) $display("FAIL wr_hit_no_mem_write: got %b required 0", mem_write); else pass_cnt++;
  endtask

  task automatic test_dirty_evict();
    proc_addr = 30'h30;
    #1;
    total_cnt++; if (proc_stall !== 1'b1) $display("FAIL evict_stall: got %b required 1", proc_stall); else pass_cnt++;
    tick();
    total_cnt++; if (mem_write !== 1'b1) $display("FAIL evict_mem_write: got %b required 1", mem_write); else pass_cnt++;
    total_cnt++; if (mem_read !== 1'b0) $display("FAIL evict_mem_read: got %b required 0", mem_read); else pass_cnt++;
    total_cnt++; if (mem_addr !== 28'h4) $display("FAIL evict_mem_addr: got %h required 0000004", mem_addr); else pass_cnt++;
    total_cnt++; if (mem_wdata[95:64] !== 32'h12345678) $display("FAIL evict_wdata_w2: got %h required 12345678", mem_wdata[95:64]); else pass_cnt++;
    total_cnt++; if (mem_wdata[31:0] !== 32'hA) $display("FAIL evict_wdata_w0: got %h required 0000000a", mem_wdata[31:0]); else pass_cnt++;
    tick();
    total_cnt++; if (mem_write !== 1'b1) $display("FAIL evict_hold: got %b required 1", mem_write); else pass_cnt++;
    mem_pulse({32'h33, 32'h32, 32'h31, 32'h30});
    total_cnt++; if (mem_write !== 1'b0) $display("FAIL evict_write_drop: got %b required 0", mem_write); else pass_cnt++;
    total_cnt++; if (mem_read !== 1'b1) $display("FAIL evict_alloc_read: got %b required 1", mem_read); else pass_cnt++;
    total_cnt++; if (mem_addr !== 28'hC) $display("FAIL evict_alloc_addr: got %h required 000000c", mem_addr); else pass_cnt++;
    total_cnt++; if (proc_stall !== 1'b1) $display("FAIL evict_alloc_stall: got %b required 1", proc_stall); else pass_cnt++;
    mem_pulse({32'h33, 32'h32, 32'h31, 32'h30});
    total_cnt++; if (proc_stall !== 1'b0) $display("FAIL evict_done_stall: got %b required 0", proc_stall); else pass_cnt++;
    total_cnt++; if (proc_rdata !== 32'h30) $display("FAIL evict_done_rdata: got %h required 00000030", proc_rdata); else pass_cnt++;
  endtask

  task automatic test_write_miss();
    proc_read = 1'b0; proc_write = 1'b1; proc_addr = 30'h100; proc_wdata = 32'h55;
    #1;
    total_cnt++; if (proc_stall !== 1'b1) $display("FAIL wmiss_stall: got %b required 1", proc_stall); else pass_cnt++;
    tick();
    total_cnt++; if (mem_read !== 1'b1) $display("FAIL wmiss_mem_read: got %b required 1", mem_read); else pass_cnt++;
    total_cnt++; if (mem_write !== 1'b0) $display("FAIL wmiss_no_mem_write: got %b required 0", mem_write); else pass_cnt++;
    total_cnt++; if (mem_addr !== 28'h40) $display("FAIL wmiss_mem_addr: got %h required 0000040", mem_addr); else pass_cnt++;
    mem_pulse({32'hA3, 32'hA2, 32'hA1, 32'hA0});
    total_cnt++; if (proc_stall !== 1'b0) $display("FAIL wmiss_hit_stall: got %b required 0", proc_stall); else pass_cnt++;
    total_cnt++; if (proc_rdata !== 32'hA0) $display("FAIL wmiss_no_merge: got %h required 000000a0", proc_rdata); else pass_cnt++;
    tick();
    proc_write = 1'b0; proc_read = 1'b1;
    #1;
    total_cnt++; if (proc_rdata !== 32'h55) $display("FAIL wmiss_word: got %h required 00000055", proc_rdata); else pass_cnt++;
    proc_addr = 30'h101;
    #1;
    total_cnt++; if (proc_rdata !== 32'hA1) $display("FAIL wmiss_neighbour: got %h required 000000a1", proc_rdata); else pass_cnt++;
    // Conflicting read in index 0 must write the dirty line back.
    proc_addr = 30'h120;
    #1;
    total_cnt++; if (proc_stall !== 1'b1) $display("FAIL wmiss_conflict_stall: got %b required 1", proc_stall); else pass_cnt++;
    tick();
    total_cnt++; if (mem_write !== 1'b1) $display("FAIL wmiss_wb_write: got %b required 1", mem_write); else pass_cnt++;
    total_cnt++; if (mem_addr !== 28'h40) $display("FAIL wmiss_wb_addr: got %h required 0000040", mem_addr); else pass_cnt++;
    total_cnt++; if (mem_wdata[31:0] !== 32'h55) $display("FAIL wmiss_wb_w0: got %h required 00000055", mem_wdata[31:0]); else pass_cnt++;
    total_cnt++; if (mem_wdata[63:32] !== 32'hA1) $display("FAIL wmiss_wb_w1: got %h required 000000a1", mem_wdata[63:32]); else pass_cnt++;
    mem_pulse('0);
    total_cnt++; if (mem_addr !== 28'h48) $display("FAIL wmiss_alloc_addr: got %h required 0000048", mem_addr); else pass_cnt++;
    mem_pulse({32'hB3, 32'hB2, 32'hB1, 32'hB0});
    total_cnt++; if (proc_rdata !== 32'hB0) $display("FAIL wmiss_conflict_rdata: got %h required 000000b0", proc_rdata); else pass_cnt++;
  endtask

  task automatic test_reset_mid_miss();
    proc_addr = 30'h40;
    #1;
    total_cnt++; if (proc_stall !== 1'b1) $display("FAIL rmid_stall: got %b required 1", proc_stall); else pass_cnt++;
    tick();
    total_cnt++; if (mem_read !== 1'b1) $display("FAIL rmid_mem_read: got %b required 1", mem_read); else pass_cnt++;
    proc_read = 1'b0; rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    total_cnt++; if (mem_read !== 1'b0) $display("FAIL rmid_read_cleared: got %b required 0", mem_read); else pass_cnt++;
    total_cnt++; if (proc_stall !== 1'b0) $display("FAIL rmid_stall_idle: got %b required 0", proc_stall); else pass_cnt++;
    mem_pulse({32'hEE, 32'hEE, 32'hEE, 32'hEE});
    total_cnt++; if (mem_read !== 1'b0) $display("FAIL rmid_late_ready_read: got %b required 0", mem_read); else pass_cnt++;
    total_cnt++; if (mem_write !== 1'b0) $display("FAIL rmid_late_ready_write: got %b required 0", mem_write); else pass_cnt++;
    proc_read = 1'b1; proc_addr = 30'h10;
    #1;
    total_cnt++; if (proc_stall !== 1'b1) $display("FAIL rmid_remiss_stall: got %b required 1", proc_stall); else pass_cnt++;
    tick();
    total_cnt++; if (mem_read !== 1'b1) $display("FAIL rmid_remiss_read: got %b required 1", mem_read); else pass_cnt++;
    total_cnt++; if (mem_addr !== 28'h4) $display("FAIL rmid_remiss_addr: got %h required 0000004", mem_addr); else pass_cnt++;
    mem_pulse({32'h4D, 32'h4C, 32'h4B, 32'h4A});
    total_cnt++; if (proc_rdata !== 32'h4A) $display("FAIL rmid_refill_rdata: got %h required 0000004a", proc_rdata); else pass_cnt++;
    proc_read = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_read_miss();
    test_read_hit();
    test_write_hit();
    test_dirty_evict();
    test_write_miss();
    test_reset_mid_miss();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
